// File: rtl/fir_ap_ctrl.sv
// fir_ap_ctrl -- block-level controller for the FIR engine.
//
// Holds the ap_ctrl and data_length configuration registers, issues a
// one-cycle ap_start to axis_in and the FIR datapath, counts accepted
// input/output samples and reports ap_done / ap_idle / len_err.
// Tap-coefficient writes are locked out while a run is in flight.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_wr_en/cfg_rd_en      one-cycle config write/read strobes
//   cfg_addr, cfg_wdata      config byte address and write data
//   cfg_rdata, cfg_rvalid    registered read data, valid 1 cycle after rd_en
//   ap_start                 one-cycle start pulse
//   in_hs, out_hs            accepted input / output sample strobes
//   out_last                 sm_tlast qualified by out_hs
//   tap_lock                 1 while tap RAM config writes must be blocked
module fir_ap_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_wr_en,
    input  logic                   cfg_rd_en,
    input  logic [pADDR_WIDTH-1:0] cfg_addr,
    input  logic [pDATA_WIDTH-1:0] cfg_wdata,
    output logic [pDATA_WIDTH-1:0] cfg_rdata,
    output logic                   cfg_rvalid,
    output logic                   ap_start,
    input  logic                   in_hs,
    input  logic                   out_hs,
    input  logic                   out_last,
    output logic                   tap_lock
);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(12'h000);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(12'h010);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32'h020);
    localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(32'h020 + 4 * (Tape_Num - 1));

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

    state_t                 state_q, state_d;
    logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;
    logic [pDATA_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [pDATA_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic                   ap_done_q, ap_done_d;
    logic                   len_err_q, len_err_d;
    logic                   ap_start_q, ap_start_d;
    logic                   ap_idle_q, ap_idle_d;
    logic                   tap_lock_q, tap_lock_d;
    logic [pDATA_WIDTH-1:0] cfg_rdata_q, cfg_rdata_d;
    logic                   cfg_rvalid_q, cfg_rvalid_d;

    logic                   wr_ctrl, wr_len, rd_ctrl, is_tap, at_last;
    logic [pDATA_WIDTH-1:0] len_m1, ctrl_word;

    always_comb begin
        wr_ctrl   = cfg_wr_en && (cfg_addr == ADDR_CTRL);
        wr_len    = cfg_wr_en && (cfg_addr == ADDR_LEN);
        rd_ctrl   = cfg_rd_en && (cfg_addr == ADDR_CTRL);
        is_tap    = (cfg_addr >= TAP_BASE) && (cfg_addr <= TAP_LAST);
        len_m1    = data_length_q - pDATA_WIDTH'(1);
        at_last   = (out_cnt_q == len_m1);
        ctrl_word = pDATA_WIDTH'({len_err_q, ap_idle_q, ap_done_q, ap_start_q});

        state_d       = state_q;
        data_length_d = data_length_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        ap_done_d     = ap_done_q;
        len_err_d     = len_err_q;

        // Read-to-clear first; any set below in the same cycle overrides it.
        if (rd_ctrl) begin
            ap_done_d = 1'b0;
            len_err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_len)
                    data_length_d = cfg_wdata;
                if (wr_ctrl && cfg_wdata[0] && (data_length_q != '0)) begin
                    state_d   = S_START;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    ap_done_d = 1'b0;
                    len_err_d = 1'b0;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                // Input count saturates at data_length; extra samples are not counted.
                if (in_hs && (in_cnt_q < data_length_q))
                    in_cnt_d = in_cnt_q + pDATA_WIDTH'(1);
                if (out_hs) begin
                    out_cnt_d = out_cnt_q + pDATA_WIDTH'(1);
                    // tlast must coincide exactly with the final counted output.
                    if (out_last != at_last)
                        len_err_d = 1'b1;
                    // Run termination is by count only, regardless of tlast.
                    if (at_last) begin
                        state_d   = S_IDLE;
                        ap_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        cfg_rvalid_d = cfg_rd_en;
        cfg_rdata_d  = '0;
        if (cfg_rd_en) begin
            if (cfg_addr == ADDR_CTRL)
                cfg_rdata_d = ctrl_word;
            else if (cfg_addr == ADDR_LEN)
                cfg_rdata_d = data_length_q;
            else if (is_tap)
                cfg_rdata_d = '0;  // tap words are served by the tap RAM, not here
        end

        ap_start_d = (state_d == S_START);
        ap_idle_d  = (state_d == S_IDLE);
        tap_lock_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            data_length_q <= '0;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            ap_done_q     <= 1'b0;
            len_err_q     <= 1'b0;
            ap_start_q    <= 1'b0;
            ap_idle_q     <= 1'b1;
            tap_lock_q    <= 1'b0;
            cfg_rdata_q   <= '0;
            cfg_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_length_q <= data_length_d;
            in_cnt_q      <= in_cnt_d;
            out_cnt_q     <= out_cnt_d;
            ap_done_q     <= ap_done_d;
            len_err_q     <= len_err_d;
            ap_start_q    <= ap_start_d;
            ap_idle_q     <= ap_idle_d;
            tap_lock_q    <= tap_lock_d;
            cfg_rdata_q   <= cfg_rdata_d;
            cfg_rvalid_q  <= cfg_rvalid_d;
        end
    end

    assign cfg_rdata  = cfg_rdata_q;
    assign cfg_rvalid = cfg_rvalid_q;
    assign ap_start   = ap_start_q;
    assign tap_lock   = tap_lock_q;

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// Bench for fir_ap_ctrl: read expectations are queued when a read is issued
// and popped when cfg_rvalid comes back.
module tb_fir_ap_ctrl;

    logic        clk, rst;
    logic        cfg_wr_en, cfg_rd_en;
    logic [11:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cfg_rvalid, ap_start, in_hs, out_hs, out_last, tap_lock;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    fir_ap_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
        .ap_start(ap_start), .in_hs(in_hs), .out_hs(out_hs),
        .out_last(out_last), .tap_lock(tap_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every returned read is compared with the oldest queued expectation.
    always @(negedge clk) begin
        if (cfg_rvalid) begin
            logic [31:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_spurious rdata=%h with nothing expected", cfg_rdata);
            end else begin
                e = exp_q.pop_front();
                if (cfg_rdata !== e) begin
                    errors++;
                    $display("FAIL rd_data got=%h exp=%h", cfg_rdata, e);
                end
            end
        end
    end

    task automatic cfg_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic cfg_read(input logic [11:0] a, input logic [31:0] e);
        @(negedge clk);
        cfg_rd_en = 1'b1; cfg_addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        cfg_rd_en = 1'b0;
        checks++;
        if (cfg_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rvalid_latency a=%h got=%b exp=1", a, cfg_rvalid);
        end
    endtask

    // Drive n output handshakes; out_last is raised on handshake number last_at (1-based).
    task automatic drive_out(input int n, input int last_at);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            out_hs = 1'b1; in_hs = 1'b1; out_last = (i == last_at);
            if (i == n) begin
                checks++;
                if (tap_lock !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_before_final got=%b exp=1", tap_lock);
                end
            end
        end
        @(negedge clk);
        out_hs = 1'b0; in_hs = 1'b0; out_last = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({ap_start, cfg_rvalid, tap_lock} !== 3'b000 || cfg_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs start=%b rvalid=%b lock=%b rdata=%h exp 0", ap_start, cfg_rvalid, tap_lock, cfg_rdata);
        end
        rst = 1'b0;
        cfg_read(12'h000, 32'h4);
        cfg_read(12'h010, 32'h0);
        cfg_read(12'h024, 32'h0);
    endtask

    task automatic test_run600;
        cfg_write(12'h010, 32'd600);
        cfg_write(12'h000, 32'h1);
        checks++;
        if (ap_start !== 1'b1 || tap_lock !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse start=%b lock=%b exp 1 1", ap_start, tap_lock);
        end
        @(negedge clk);
        checks++;
        if (ap_start !== 1'b0 || tap_lock !== 1'b1) begin
            errors++;
            $display("FAIL start_one_cycle start=%b lock=%b exp 0 1", ap_start, tap_lock);
        end
        cfg_read(12'h000, 32'h0);
        drive_out(600, 600);
        checks++;
        if (tap_lock !== 1'b0) begin
            errors++;
            $display("FAIL lock_after_run got=%b exp=0", tap_lock);
        end
        cfg_read(12'h000, 32'h6);
        cfg_read(12'h000, 32'h4);
    endtask

    task automatic test_zero_len;
        cfg_write(12'h010, 32'd0);
        cfg_write(12'h000, 32'h1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ap_start !== 1'b0 || tap_lock !== 1'b0) begin
                errors++;
                $display("FAIL zero_len_start cyc=%0d start=%b lock=%b exp 0 0", i, ap_start, tap_lock);
            end
            @(negedge clk);
        end
        cfg_read(12'h000, 32'h4);
    endtask

    task automatic test_busy_writes;
        cfg_write(12'h010, 32'd600);
        cfg_write(12'h000, 32'h1);
        @(negedge clk);
        cfg_write(12'h010, 32'd5);
        cfg_write(12'h000, 32'h1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ap_start !== 1'b0) begin
                errors++;
                $display("FAIL restart_in_run cyc=%0d start=%b exp=0", i, ap_start);
            end
            @(negedge clk);
        end
        cfg_read(12'h010, 32'd600);
        drive_out(600, 600);
        cfg_read(12'h000, 32'h6);
    endtask

    task automatic test_len_err;
        cfg_write(12'h010, 32'd4);
        cfg_write(12'h000, 32'h1);
        drive_out(4, 3);
        checks++;
        if (tap_lock !== 1'b0) begin
            errors++;
            $display("FAIL len_err_run_end lock=%b exp=0", tap_lock);
        end
        cfg_read(12'h000, 32'hE);
        cfg_read(12'h000, 32'h4);
    endtask

    // Read of 0x000 on the same cycle ap_done sets: old value returned, set wins.
    task automatic test_done_collision;
        cfg_write(12'h010, 32'd2);
        cfg_write(12'h000, 32'h1);
        @(negedge clk);
        out_hs = 1'b1; out_last = 1'b0;
        @(negedge clk);
        out_last = 1'b1; cfg_rd_en = 1'b1; cfg_addr = 12'h000;
        exp_q.push_back(32'h0);
        @(negedge clk);
        out_hs = 1'b0; out_last = 1'b0; cfg_rd_en = 1'b0;
        cfg_read(12'h000, 32'h6);
        cfg_read(12'h000, 32'h4);
    endtask

    task automatic test_mid_reset;
        cfg_write(12'h010, 32'd600);
        cfg_write(12'h000, 32'h1);
        drive_out(10, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (tap_lock !== 1'b0 || ap_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset lock=%b start=%b exp 0 0", tap_lock, ap_start);
        end
        @(negedge clk);
        rst = 1'b0;
        cfg_read(12'h000, 32'h4);
        cfg_read(12'h010, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_hs = 1'b0; out_hs = 1'b0; out_last = 1'b0;
        test_reset;
        test_run600;
        test_zero_len;
        test_busy_writes;
        test_len_err;
        test_done_collision;
        test_mid_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_missing outstanding=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
